arrow_queue: RTL and testbench

Downstream consumer of the game's random arrow generator. Samples one 5-bit arrow code per scroll tick into a DEPTH-slot shifting queue, drives the head slot's 7-segment pattern, and judges debounced player buttons against the head arrow. It emits hit/miss pulses and a saturating score for the scoreboard/display stage. Follows the game's global state input: GAME, PAUSE, RESET.

---
 rtl/arrow_pkg.sv | 89 ++++++++
 rtl/arrow_decode.sv | 38 +++
 rtl/arrow_queue.sv | 160 ++++++++++++++++
 tb/tb_arrow_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// -----------------------------------------------------------------------------
// arrow_pkg
// Shared definitions for the arrow queue: game-state codes, arrow codes
// (10..20), 7-segment patterns (active low) and the code->button-mask /
// code->segment functions used by arrow_decode.
// Build option: ARROW_QUEUE_COMBO_EN (consumed in arrow_decode) selects whether
// combo codes are kept or reduced to their first component at load time.
// -----------------------------------------------------------------------------
package arrow_pkg;

  // Global game state as driven by the game controller; 3 behaves as PAUSE.
  typedef enum logic [1:0] {
    GS_GAME      = 2'd0,
    GS_PAUSE     = 2'd1,
    GS_RESET     = 2'd2,
    GS_PAUSE_ALT = 2'd3
  } game_state_e;

  // Local queue FSM.
  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_RUN  = 2'd1,
    Q_HOLD = 2'd2
  } q_state_e;

  localparam logic [4:0] ARROW_UP         = 5'd10;
  localparam logic [4:0] ARROW_DOWN       = 5'd11;
  localparam logic [4:0] ARROW_LEFT       = 5'd12;
  localparam logic [4:0] ARROW_RIGHT      = 5'd13;
  localparam logic [4:0] ARROW_UP_DOWN    = 5'd14;
  localparam logic [4:0] ARROW_UP_LEFT    = 5'd15;
  localparam logic [4:0] ARROW_UP_RIGHT   = 5'd16;
  localparam logic [4:0] ARROW_DOWN_LEFT  = 5'd17;
  localparam logic [4:0] ARROW_DOWN_RIGHT = 5'd18;
  localparam logic [4:0] ARROW_LEFT_RIGHT = 5'd19;
  localparam logic [4:0] ARROW_NONE       = 5'd20;

  // Active-low segment patterns of the four base arrows.
  localparam logic [6:0] SEG_ARROW_UP    = 7'b1111110;
  localparam logic [6:0] SEG_ARROW_DOWN  = 7'b1110111;
  localparam logic [6:0] SEG_ARROW_LEFT  = 7'b1001111;
  localparam logic [6:0] SEG_ARROW_RIGHT = 7'b1111001;
  localparam logic [6:0] SEG_ARROW_NONE  = 7'b1111111;

  // Button masks in {up, down, left, right} order.
  localparam logic [3:0] MASK_UP    = 4'b1000;
  localparam logic [3:0] MASK_DOWN  = 4'b0100;
  localparam logic [3:0] MASK_LEFT  = 4'b0010;
  localparam logic [3:0] MASK_RIGHT = 4'b0001;

  // Buttons that must be pressed to clear an arrow; combos need both parts.
  function automatic logic [3:0] arrow_mask(input logic [4:0] code);
    logic [3:0] m;
    case (code)
      ARROW_UP:         m = MASK_UP;
      ARROW_DOWN:       m = MASK_DOWN;
      ARROW_LEFT:       m = MASK_LEFT;
      ARROW_RIGHT:      m = MASK_RIGHT;
      ARROW_UP_DOWN:    m = MASK_UP   | MASK_DOWN;
      ARROW_UP_LEFT:    m = MASK_UP   | MASK_LEFT;
      ARROW_UP_RIGHT:   m = MASK_UP   | MASK_RIGHT;
      ARROW_DOWN_LEFT:  m = MASK_DOWN | MASK_LEFT;
      ARROW_DOWN_RIGHT: m = MASK_DOWN | MASK_RIGHT;
      ARROW_LEFT_RIGHT: m = MASK_LEFT | MASK_RIGHT;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

  // Segments are active low, so a combo lights the union of its parts (AND).
  function automatic logic [6:0] arrow_seg(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      ARROW_UP:         s = SEG_ARROW_UP;
      ARROW_DOWN:       s = SEG_ARROW_DOWN;
      ARROW_LEFT:       s = SEG_ARROW_LEFT;
      ARROW_RIGHT:      s = SEG_ARROW_RIGHT;
      ARROW_UP_DOWN:    s = SEG_ARROW_UP   & SEG_ARROW_DOWN;
      ARROW_UP_LEFT:    s = SEG_ARROW_UP   & SEG_ARROW_LEFT;
      ARROW_UP_RIGHT:   s = SEG_ARROW_UP   & SEG_ARROW_RIGHT;
      ARROW_DOWN_LEFT:  s = SEG_ARROW_DOWN & SEG_ARROW_LEFT;
      ARROW_DOWN_RIGHT: s = SEG_ARROW_DOWN & SEG_ARROW_RIGHT;
      ARROW_LEFT_RIGHT: s = SEG_ARROW_LEFT & SEG_ARROW_RIGHT;
      default:          s = SEG_ARROW_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/arrow_decode.sv
// -----------------------------------------------------------------------------
// arrow_decode
// Combinational arrow decoder plus the tail load filter.
//   code_i  [4:0]  code to decode (the head slot)
//   raw_i   [4:0]  raw code from the random generator
//   dec_o   [10:0] {seg[6:0] active-low pattern, mask[3:0] {u,d,l,r}}
//   load_o  [4:0]  raw_i after filtering: out-of-range -> NONE, combos reduced
//                  to their first component unless ARROW_QUEUE_COMBO_EN is
//                  defined.
// -----------------------------------------------------------------------------
module arrow_decode
  import arrow_pkg::*;
(
  input  logic [4:0]  code_i,
  input  logic [4:0]  raw_i,
  output logic [10:0] dec_o,
  output logic [4:0]  load_o
);

  assign dec_o = {arrow_seg(code_i), arrow_mask(code_i)};

  always_comb begin
    load_o = ARROW_NONE;
    if (raw_i >= ARROW_UP && raw_i <= ARROW_NONE) begin
`ifdef ARROW_QUEUE_COMBO_EN
      load_o = raw_i;
`else
      case (raw_i)
        ARROW_UP_DOWN, ARROW_UP_LEFT, ARROW_UP_RIGHT: load_o = ARROW_UP;
        ARROW_DOWN_LEFT, ARROW_DOWN_RIGHT:            load_o = ARROW_DOWN;
        ARROW_LEFT_RIGHT:                             load_o = ARROW_LEFT;
        default:                                      load_o = raw_i;
      endcase
`endif
    end
  end

endmodule

// File: rtl/arrow_queue.sv
// -----------------------------------------------------------------------------
// arrow_queue
// Shifting queue of arrow codes fed once per scroll tick, with button judging
// against the head slot, hit/miss pulses and a saturating score.
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   state  [1:0]  game state: 0 GAME, 1 PAUSE, 2 RESET, 3 PAUSE
//   random_arrow  [4:0] arrow code from the generator
//   btn    [3:0]  debounced buttons {up, down, left, right}
//   queue  [5*DEPTH-1:0] slot codes, slot i at [5i+4:5i], slot 0 is the head
//   seg_head [6:0] active-low segments of slot 0 (combinational)
//   score  [SCORE_BITS-1:0] saturating hit count
//   hit, miss     one-cycle pulses
// Build option: ARROW_QUEUE_COMBO_EN keeps combo codes 14..19 at load.
// -----------------------------------------------------------------------------
module arrow_queue
  import arrow_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int TICK_DIV   = 25_000_000,
  parameter int SCORE_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            state,
  input  logic [4:0]            random_arrow,
  input  logic [3:0]            btn,
  output logic [5*DEPTH-1:0]    queue,
  output logic [6:0]            seg_head,
  output logic [SCORE_BITS-1:0] score,
  output logic                  hit,
  output logic                  miss
);

  localparam int               CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  q_state_e              fsm_q, fsm_d;
  logic [4:0]            slot_q [DEPTH];
  logic [4:0]            slot_d [DEPTH];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            press_q, press_d;
  logic [3:0]            btn_s_q, btn_q;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic                  hit_q, hit_d, miss_q, miss_d;

  logic [10:0] head_dec;
  logic [6:0]  head_seg;
  logic [3:0]  head_mask;
  logic [4:0]  load_code;
  logic [3:0]  edges, press_acc;
  logic        tick, head_live;

  arrow_decode u_decode (
    .code_i (slot_q[0]),
    .raw_i  (random_arrow),
    .dec_o  (head_dec),
    .load_o (load_code)
  );

  assign head_seg  = head_dec[10:4];
  assign head_mask = head_dec[3:0];

  // btn_s_q is the input sample; edges are judged one cycle after a button is
  // first sampled high, so hit/miss appear two edges after btn rises.
  assign edges     = btn_s_q & ~btn_q;
  assign press_acc = press_q | edges;
  assign tick      = (cnt_q == CNT_LAST);
  assign head_live = (slot_q[0] != ARROW_NONE);

  // Queue FSM next state.
  always_comb begin
    fsm_d = fsm_q;
    case (game_state_e'(state))
      GS_GAME:  fsm_d = Q_RUN;
      GS_RESET: fsm_d = Q_IDLE;
      default:  if (fsm_q == Q_RUN) fsm_d = Q_HOLD;
    endcase
  end

  // Datapath follows the state being entered, so GAME/PAUSE/RESET take effect
  // on the very next edge (RESET clears without any pulse).
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_d[i] = slot_q[i];
    cnt_d   = cnt_q;
    press_d = press_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    case (fsm_d)
      Q_IDLE: begin
        for (int i = 0; i < DEPTH; i++) slot_d[i] = ARROW_NONE;
        cnt_d   = '0;
        press_d = '0;
        score_d = '0;
      end
      Q_RUN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick) begin
          // Tick wins over any same-cycle button edge.
          for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i + 1];
          slot_d[DEPTH-1] = load_code;
          press_d         = '0;
          miss_d          = head_live;
        end else if (head_live && (edges != 4'b0000)) begin
          if ((press_acc & ~head_mask) != 4'b0000) begin
            miss_d    = 1'b1;
            slot_d[0] = ARROW_NONE;
            press_d   = '0;
          end else if (press_acc == head_mask) begin
            hit_d     = 1'b1;
            slot_d[0] = ARROW_NONE;
            press_d   = '0;
            score_d   = (score_q == {SCORE_BITS{1'b1}}) ? score_q : score_q + 1'b1;
          end else begin
            press_d = press_acc;
          end
        end
      end
      default: ; // HOLD: everything frozen
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= Q_IDLE;
      cnt_q   <= '0;
      press_q <= '0;
      btn_s_q <= '0;
      btn_q   <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= ARROW_NONE;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      btn_s_q <= btn;
      btn_q   <= btn_s_q;
      score_q <= score_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pack
      assign queue[5*gi +: 5] = slot_q[gi];
    end
  endgenerate

  assign seg_head = head_seg;
  assign score    = score_q;
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_arrow_queue.sv
// -----------------------------------------------------------------------------
// tb_arrow_queue
// Self-checking bench for arrow_queue (DEPTH=4, TICK_DIV=4). A second instance
// with SCORE_BITS=2 shares the stimulus to exercise score saturation.
// Expectations follow ARROW_QUEUE_COMBO_EN when it is defined for the build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arrow_queue;

  localparam logic [4:0] NONE     = 5'd20;
  localparam logic [1:0] ST_GAME  = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_RESET = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  state;
  logic [4:0]  random_arrow;
  logic [3:0]  btn;
  logic [19:0] queue;
  logic [6:0]  seg_head;
  logic [7:0]  score;
  logic        hit, miss;
  logic [19:0] queue_s;
  logic [6:0]  seg_s;
  logic [1:0]  score_s;
  logic        hit_s, miss_s;

  always #5 clk = ~clk;

  arrow_queue #(.DEPTH(4), .TICK_DIV(4), .SCORE_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .random_arrow(random_arrow), .btn(btn),
    .queue(queue), .seg_head(seg_head), .score(score), .hit(hit), .miss(miss)
  );

  arrow_queue #(.DEPTH(4), .TICK_DIV(4), .SCORE_BITS(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .state(state), .random_arrow(random_arrow), .btn(btn),
    .queue(queue_s), .seg_head(seg_s), .score(score_s), .hit(hit_s), .miss(miss_s)
  );

  typedef struct packed {
    logic       hit;
    logic       miss;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_score = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full scroll period; a is shifted into the tail at its last edge.
  task automatic feed(input logic [4:0] a);
    random_arrow = a;
    repeat (4) cyc();
  endtask

  // Clear via state=RESET, then run: the counter restarts at 0.
  task automatic restart();
    state = ST_RESET; btn = 4'b0000; random_arrow = NONE;
    cyc();
    state = ST_GAME;
    exp_score = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    n_cmp++;
    if (queue !== {4{NONE}} || seg_head !== 7'b1111111) begin
      n_bad++; $display("FAIL reset queue/seg: got %h/%b, want %h/1111111", queue, seg_head, {4{NONE}});
    end
    n_cmp++;
    if (score !== 8'd0 || hit !== 1'b0 || miss !== 1'b0 || score_s !== 2'd0) begin
      n_bad++; $display("FAIL reset outputs: got score=%0d hit=%0b miss=%0b, want 0/0/0", score, hit, miss);
    end
  endtask

  task automatic test_tail_load();
    exp_t e;
    restart();
    random_arrow = 5'd10;
    for (int t = 1; t <= 19; t++) begin
      cyc();
      n_cmp++;
      if (hit !== 1'b0 || miss !== 1'b0) begin
        n_bad++; $display("FAIL tail_load early pulse t=%0d: got hit=%0b miss=%0b, want 0/0", t, hit, miss);
      end
      if (t == 16) begin
        n_cmp++;
        if (queue !== {4{5'd10}} || seg_head !== 7'b1111110) begin
          n_bad++; $display("FAIL tail_load queue: got %h seg=%b, want %h seg=1111110", queue, seg_head, {4{5'd10}});
        end
        sb.push_back('{hit: 1'b0, miss: 1'b1, score: 8'd0});
      end
    end
    cyc();
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL tail_load shift-out: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    $display("tail_load: shift-out hit=%0b miss=%0b score=%0d", hit, miss, score);
    cyc();
    n_cmp++;
    if (miss !== 1'b0) begin
      n_bad++; $display("FAIL tail_load pulse width: got miss=%0b, want 0", miss);
    end
  endtask

  task automatic test_single_hit();
    exp_t e;
    restart();
    feed(5'd13); feed(NONE); feed(NONE); feed(NONE);
    n_cmp++;
    if (queue[4:0] !== 5'd13 || seg_head !== 7'b1111001) begin
      n_bad++; $display("FAIL single_hit head: got %0d seg=%b, want 13 seg=1111001", queue[4:0], seg_head);
    end
    exp_score++;
    sb.push_back('{hit: 1'b1, miss: 1'b0, score: 8'(exp_score)});
    btn = 4'b0001;
    cyc();
    n_cmp++;
    if (hit !== 1'b0 || miss !== 1'b0 || score !== 8'd0) begin
      n_bad++; $display("FAIL single_hit early: got hit=%0b miss=%0b score=%0d, want 0/0/0", hit, miss, score);
    end
    btn = 4'b0000;
    cyc();
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL single_hit judge: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    $display("single_hit: hit=%0b miss=%0b score=%0d", hit, miss, score);
    n_cmp++;
    if (queue[4:0] !== NONE || seg_head !== 7'b1111111) begin
      n_bad++; $display("FAIL single_hit clear: got head=%0d seg=%b, want 20 seg=1111111", queue[4:0], seg_head);
    end
    cyc();
    n_cmp++;
    if (hit !== 1'b0) begin
      n_bad++; $display("FAIL single_hit pulse width: got hit=%0b, want 0", hit);
    end
  endtask

  task automatic test_wrong_button();
    exp_t e;
    restart();
    feed(5'd10); feed(NONE); feed(NONE); feed(NONE);
    sb.push_back('{hit: 1'b0, miss: 1'b1, score: 8'd0});
    btn = 4'b0010;
    cyc();
    btn = 4'b0000;
    cyc();
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL wrong_button judge: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    $display("wrong_button: hit=%0b miss=%0b score=%0d", hit, miss, score);
    n_cmp++;
    if (queue[4:0] !== NONE) begin
      n_bad++; $display("FAIL wrong_button clear: got head=%0d, want 20", queue[4:0]);
    end
  endtask

  task automatic test_combo();
    exp_t e18, e19;
    restart();
    feed(5'd15); feed(NONE); feed(NONE); feed(NONE);
`ifdef ARROW_QUEUE_COMBO_EN
    n_cmp++;
    if (queue[4:0] !== 5'd15 || seg_head !== 7'b1001110) begin
      n_bad++; $display("FAIL combo head: got %0d seg=%b, want 15 seg=1001110", queue[4:0], seg_head);
    end
    e18 = '{hit: 1'b0, miss: 1'b0, score: 8'd0};
    e19 = '{hit: 1'b1, miss: 1'b0, score: 8'd1};
`else
    n_cmp++;
    if (queue[4:0] !== 5'd10 || seg_head !== 7'b1111110) begin
      n_bad++; $display("FAIL combo filter: got %0d seg=%b, want 10 seg=1111110", queue[4:0], seg_head);
    end
    e18 = '{hit: 1'b1, miss: 1'b0, score: 8'd1};
    e19 = '{hit: 1'b0, miss: 1'b0, score: 8'd1};
`endif
    sb.push_back(e18);
    sb.push_back(e19);
    btn = 4'b1000;          // up first
    cyc();
    btn = 4'b1010;          // left joins a cycle later
    cyc();
    e18 = sb.pop_front();
    n_cmp++;
    if (hit !== e18.hit || miss !== e18.miss || score !== e18.score) begin
      n_bad++; $display("FAIL combo first press: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e18.hit, e18.miss, e18.score);
    end
    cyc();
    e19 = sb.pop_front();
    n_cmp++;
    if (hit !== e19.hit || miss !== e19.miss || score !== e19.score) begin
      n_bad++; $display("FAIL combo second press: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e19.hit, e19.miss, e19.score);
    end
    $display("combo: hit=%0b miss=%0b score=%0d", hit, miss, score);
    btn = 4'b0000;
  endtask

  task automatic test_collision();
    exp_t e;
    restart();
    feed(5'd12); feed(5'd12); feed(NONE); feed(NONE);
    cyc(); cyc();                 // t=18
    btn = 4'b0010;                // edge lands in the tick cycle
    sb.push_back('{hit: 1'b0, miss: 1'b1, score: 8'd0});
    cyc();
    n_cmp++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      n_bad++; $display("FAIL collision early: got hit=%0b miss=%0b, want 0/0", hit, miss);
    end
    cyc();                        // t=20, shift edge
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL collision tick: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    $display("collision tick: hit=%0b miss=%0b score=%0d", hit, miss, score);
    n_cmp++;
    if (queue[4:0] !== 5'd12 || queue[9:5] !== NONE) begin
      n_bad++; $display("FAIL collision shift: got head=%0d slot1=%0d, want 12/20", queue[4:0], queue[9:5]);
    end
    btn = 4'b0000;
    cyc();
    n_cmp++;
    if (hit !== 1'b0 || miss !== 1'b0) begin
      n_bad++; $display("FAIL collision discard: got hit=%0b miss=%0b, want 0/0", hit, miss);
    end
    btn = 4'b0010;
    exp_score++;
    sb.push_back('{hit: 1'b1, miss: 1'b0, score: 8'(exp_score)});
    cyc();
    btn = 4'b0000;
    cyc();                        // t=23
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL collision repress: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    $display("collision repress: hit=%0b miss=%0b score=%0d", hit, miss, score);
  endtask

  task automatic test_pause();
    restart();
    feed(5'd11);                  // t=4, tail=11
    random_arrow = 5'd13;
    cyc(); cyc();                 // t=6, counter at 2
    state = ST_PAUSE;
    btn = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (queue !== {5'd11, NONE, NONE, NONE} || score !== 8'd0 || hit !== 1'b0 || miss !== 1'b0) begin
        n_bad++; $display("FAIL pause freeze i=%0d: got queue=%h score=%0d hit=%0b miss=%0b, want %h/0/0/0", i, queue, score, hit, miss, {5'd11, NONE, NONE, NONE});
      end
    end
    state = ST_GAME;
    btn = 4'b0000;
    cyc();
    n_cmp++;
    if (queue !== {5'd11, NONE, NONE, NONE}) begin
      n_bad++; $display("FAIL pause resume early: got %h, want %h", queue, {5'd11, NONE, NONE, NONE});
    end
    cyc();
    n_cmp++;
    if (queue !== {5'd13, 5'd11, NONE, NONE}) begin
      n_bad++; $display("FAIL pause resume tick: got %h, want %h", queue, {5'd13, 5'd11, NONE, NONE});
    end
    $display("pause: queue=%h after resume", queue);
  endtask

  task automatic test_state_reset_saturation();
    exp_t e;
    int   sat;
    restart();
    feed(5'd13); feed(5'd13); feed(5'd13); feed(5'd13);
    for (int k = 0; k < 5; k++) begin
      exp_score++;
      sb.push_back('{hit: 1'b1, miss: 1'b0, score: 8'(exp_score)});
      btn = 4'b0001;
      cyc();
      btn = 4'b0000;
      cyc();
      e = sb.pop_front();
      n_cmp++;
      if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
        n_bad++; $display("FAIL score hit %0d: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", k, hit, miss, score, e.hit, e.miss, e.score);
      end
      sat = (exp_score > 3) ? 3 : exp_score;
      n_cmp++;
      if (score_s !== 2'(sat) || hit_s !== 1'b1) begin
        n_bad++; $display("FAIL saturation hit %0d: got score=%0d hit=%0b, want %0d/1", k, score_s, hit_s, sat);
      end
      $display("score hit %0d: score=%0d sat_score=%0d", k, score, score_s);
      cyc(); cyc();
    end
    btn = 4'b0001;                // press pending when RESET arrives
    cyc();
    state = ST_RESET;
    btn = 4'b0000;
    cyc();
    n_cmp++;
    if (score !== 8'd0 || queue !== {4{NONE}} || hit !== 1'b0 || miss !== 1'b0) begin
      n_bad++; $display("FAIL state_reset: got score=%0d queue=%h hit=%0b miss=%0b, want 0/%h/0/0", score, queue, hit, miss, {4{NONE}});
    end
    n_cmp++;
    if (score_s !== 2'd0 || hit_s !== 1'b0 || miss_s !== 1'b0) begin
      n_bad++; $display("FAIL state_reset sat: got score=%0d hit=%0b miss=%0b, want 0/0/0", score_s, hit_s, miss_s);
    end
    state = ST_GAME;
  endtask

  task automatic test_async_reset();
    exp_t e;
    restart();
    feed(5'd13); feed(5'd13); feed(5'd13); feed(5'd13);
    exp_score++;
    sb.push_back('{hit: 1'b1, miss: 1'b0, score: 8'(exp_score)});
    btn = 4'b0001;
    cyc();
    btn = 4'b0000;
    cyc();
    e = sb.pop_front();
    n_cmp++;
    if (hit !== e.hit || miss !== e.miss || score !== e.score) begin
      n_bad++; $display("FAIL async pre-hit: got hit=%0b miss=%0b score=%0d, want %0b/%0b/%0d", hit, miss, score, e.hit, e.miss, e.score);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (hit !== 1'b0 || score !== 8'd0 || queue !== {4{NONE}} || seg_head !== 7'b1111111) begin
      n_bad++; $display("FAIL async reset: got hit=%0b score=%0d queue=%h seg=%b, want 0/0/%h/1111111", hit, score, queue, seg_head, {4{NONE}});
    end
    n_cmp++;
    if (seg_s !== 7'b1111111 || queue_s !== {4{NONE}} || score_s !== 2'd0) begin
      n_bad++; $display("FAIL async reset sat: got seg=%b queue=%h score=%0d", seg_s, queue_s, score_s);
    end
    $display("async reset: hit=%0b score=%0d queue=%h", hit, score, queue);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; state = ST_RESET; btn = 4'b0000; random_arrow = NONE;
    #12;
    test_reset();
    rst_n = 1'b1;
    test_tail_load();
    test_single_hit();
    test_wrong_button();
    test_combo();
    test_collision();
    test_pause();
    test_state_reset_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
